// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings used by the writeback path: result-source selects,
// load funct3 codes and the datapath width.
package rv32i_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } ld_f3_e;

endpackage

// File: rtl/load_extract.sv
// Combinational load formatter: picks the byte/halfword/word addressed by the
// low address bits out of an aligned memory word, sign/zero-extends it, and
// flags misaligned accesses and unknown funct3 codes. On error data is 0.
module load_extract
  import rv32i_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select: byte by full offset, halfword by offset[1] only.
  always_comb begin
    w_byte = rdata[7:0];
    case (offset)
      2'd0: w_byte = rdata[7:0];
      2'd1: w_byte = rdata[15:8];
      2'd2: w_byte = rdata[23:16];
      2'd3: w_byte = rdata[31:24];
      default: w_byte = rdata[7:0];
    endcase
    w_half = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension and alignment/legality check.
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{w_byte[7]}}, w_byte};
      F3_LBU: data = {24'd0, w_byte};
      F3_LH:  if (offset[0]) err = 1'b1;
              else           data = {{16{w_half[15]}}, w_half};
      F3_LHU: if (offset[0]) err = 1'b1;
              else           data = {16'd0, w_half};
      F3_LW:  if (offset != 2'd0) err = 1'b1;
              else                data = rdata;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register. Selects the writeback value (ALU, formatted load,
// or PC+4), qualifies the register-file write, and registers everything with
// one cycle of latency. flush beats stall beats capture; a held slot drops its
// load_err pulse after one cycle so the error is reported exactly once.
// Optional: define MEM_WB_RETIRE_COUNT_EN to add a 64-bit retired-instruction
// counter on output instret.
module mem_wb_stage
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [4:0]      in_rd,
  input  logic            in_RegWrite,
  input  logic [1:0]      in_wb_sel,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [XLEN-1:0] in_mem_rdata,
  output logic [4:0]      rd,
  output logic            RegWrite,
  output logic [XLEN-1:0] C,
  output logic            wb_valid,
  output logic            load_err
`ifdef MEM_WB_RETIRE_COUNT_EN
  ,
  output logic [63:0]     instret
`endif
);

  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_err;
  logic [4:0]      w_rd;
  logic            w_we;
  logic [XLEN-1:0] w_c;
  logic            w_valid;
  logic            w_err;

  logic [4:0]      r_rd;
  logic            r_we;
  logic [XLEN-1:0] r_c;
  logic            r_valid;
  logic            r_err;

  load_extract u_load_extract (
    .funct3 (in_funct3),
    .offset (in_alu_result[1:0]),
    .rdata  (in_mem_rdata),
    .data   (w_ld_data),
    .err    (w_ld_err)
  );

  // Next slot contents; an empty MEM slot produces an all-zero WB slot.
  always_comb begin
    w_rd    = '0;
    w_we    = 1'b0;
    w_c     = '0;
    w_valid = 1'b0;
    w_err   = 1'b0;
    if (in_valid) begin
      w_valid = 1'b1;
      w_rd    = in_rd;
      w_err   = (in_wb_sel == WB_LOAD) && w_ld_err;
      case (in_wb_sel)
        WB_ALU:  w_c = in_alu_result;
        WB_LOAD: w_c = w_ld_data;
        WB_PC4:  w_c = in_pc_plus4;
        default: w_c = '0;
      endcase
      // x0 writes, reserved selects and faulting loads never reach the bank.
      w_we = in_RegWrite && (in_rd != 5'd0) && !w_err && (in_wb_sel != WB_RSVD);
    end
  end

  // Stage register: flush > stall > capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd    <= '0;
      r_we    <= 1'b0;
      r_c     <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_rd    <= '0;
      r_we    <= 1'b0;
      r_c     <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (stall) begin
      r_err   <= 1'b0;
    end else begin
      r_rd    <= w_rd;
      r_we    <= w_we;
      r_c     <= w_c;
      r_valid <= w_valid;
      r_err   <= w_err;
    end
  end

  assign rd       = r_rd;
  assign RegWrite = r_we;
  assign C        = r_c;
  assign wb_valid = r_valid;
  assign load_err = r_err;

`ifdef MEM_WB_RETIRE_COUNT_EN
  logic [63:0] r_instret;

  // Count every captured valid instruction, faulting loads included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               r_instret <= '0;
    else if (!flush && !stall && in_valid)  r_instret <= r_instret + 64'd1;
  end

  assign instret = r_instret;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: the driver pushes hand-computed expected
// outputs per clock edge; a monitor pops and compares just after each edge.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        in_RegWrite = 1'b0;
  logic [1:0]  in_wb_sel = '0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_alu_result = '0, in_pc_plus4 = '0, in_mem_rdata = '0;
  logic [4:0]  rd;
  logic        RegWrite;
  logic [31:0] C;
  logic        wb_valid;
  logic        load_err;
`ifdef MEM_WB_RETIRE_COUNT_EN
  logic [63:0] instret;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] c;
    logic        v;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_rd(in_rd), .in_RegWrite(in_RegWrite), .in_wb_sel(in_wb_sel),
    .in_funct3(in_funct3), .in_alu_result(in_alu_result),
    .in_pc_plus4(in_pc_plus4), .in_mem_rdata(in_mem_rdata),
    .rd(rd), .RegWrite(RegWrite), .C(C), .wb_valid(wb_valid),
    .load_err(load_err)
`ifdef MEM_WB_RETIRE_COUNT_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  task automatic cmp(input exp_t e);
    checks++;
    if (rd !== e.rd || RegWrite !== e.we || C !== e.c || wb_valid !== e.v || load_err !== e.err) begin
      errors++;
      $display("FAIL vec%0d: got rd=%0d we=%b C=%h v=%b err=%b, want rd=%0d we=%b C=%h v=%b err=%b",
               e.id, rd, RegWrite, C, wb_valid, load_err, e.rd, e.we, e.c, e.v, e.err);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [4:0] r, input logic w,
                              input logic [31:0] c, input logic v, input logic er);
    exp_t e;
    e.id = id; e.rd = r; e.we = w; e.c = c; e.v = v; e.err = er;
    return e;
  endfunction

  // Drive one cycle of inputs, then queue what should appear after the edge.
  task automatic issue(input logic st, input logic fl, input logic v, input logic [4:0] r,
                       input logic we, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] mrd,
                       input exp_t e);
    stall = st; flush = fl; in_valid = v; in_rd = r; in_RegWrite = we;
    in_wb_sel = sel; in_funct3 = f3; in_alu_result = alu; in_pc_plus4 = pc;
    in_mem_rdata = mrd;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one expected entry per edge while the driver is issuing.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      cmp(m_e);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    cmp(mk(0, 0, 0, 0, 0, 0));            // in reset
    #1 rst = 1'b1;
    @(negedge clk);

    // Load formatting and result selection
    issue(0,0,1, 5, 1, 2'b01, 3'b000, 32'h3,    0, 32'h80FF_0000, mk(1, 5, 1, 32'hFFFF_FF80, 1, 0));
    issue(0,0,1, 6, 1, 2'b01, 3'b101, 32'h1002, 0, 32'hBEEF_1234, mk(2, 6, 1, 32'h0000_BEEF, 1, 0));
    issue(0,0,1, 7, 1, 2'b01, 3'b010, 32'h2,    0, 32'hBEEF_1234, mk(3, 7, 0, 32'h0, 1, 1));
    issue(0,0,1, 0, 1, 2'b00, 3'b000, 32'h1234, 0, 0,             mk(4, 0, 0, 32'h1234, 1, 0));
    issue(0,0,1, 1, 1, 2'b10, 3'b000, 32'h9,    32'h104, 0,       mk(5, 1, 1, 32'h104, 1, 0));
    issue(0,0,1, 3, 1, 2'b01, 3'b001, 32'h1,    0, 32'h1234_5678, mk(6, 3, 0, 32'h0, 1, 1));
    issue(0,0,1, 3, 1, 2'b01, 3'b011, 32'h0,    0, 32'h1234_5678, mk(7, 3, 0, 32'h0, 1, 1));
    issue(0,0,1, 9, 1, 2'b01, 3'b001, 32'h2,    0, 32'h8001_0000, mk(8, 9, 1, 32'hFFFF_8001, 1, 0));
    issue(0,0,1, 8, 1, 2'b01, 3'b100, 32'h1,    0, 32'h0000_F000, mk(9, 8, 1, 32'h0000_00F0, 1, 0));
    issue(0,0,1, 4, 1, 2'b11, 3'b000, 32'h5,    0, 0,             mk(10, 4, 0, 32'h0, 1, 0));
    issue(0,0,0, 4, 1, 2'b00, 3'b000, 32'h5,    0, 0,             mk(11, 0, 0, 32'h0, 0, 0));
    issue(0,0,1, 2, 0, 2'b00, 3'b000, 32'hAA,   0, 0,             mk(12, 2, 0, 32'hAA, 1, 0));

    // Faulting load then stall: pulse once, rest holds; flush+stall clears.
    issue(0,0,1, 11, 1, 2'b01, 3'b010, 32'h1, 0, 32'h1, mk(13, 11, 0, 0, 1, 1));
    for (int i = 0; i < 3; i++)
      issue(1,0,1, 5'(12+i), 1, 2'b00, 3'b000, 32'(i+1), 0, 0, mk(14+i, 11, 0, 0, 1, 0));
    issue(1,1,1, 12, 1, 2'b00, 3'b000, 32'h1, 0, 0, mk(17, 0, 0, 0, 0, 0));

    // Plain stall of a writing ALU op, then flush alone.
    issue(0,0,1, 10, 1, 2'b00, 3'b000, 32'h55, 0, 0, mk(18, 10, 1, 32'h55, 1, 0));
    for (int i = 0; i < 3; i++)
      issue(1,0,1, 5'(20+i), 1, 2'b10, 3'b000, 32'h0, 32'(i*4), 0, mk(19+i, 10, 1, 32'h55, 1, 0));
    issue(0,1,1, 20, 1, 2'b00, 3'b000, 32'h66, 0, 0, mk(22, 0, 0, 0, 0, 0));

    // Reset asserted mid-stall between edges.
    issue(0,0,1, 13, 1, 2'b00, 3'b000, 32'h77, 0, 0, mk(23, 13, 1, 32'h77, 1, 0));
    stall = 1'b1;
    #2 rst = 1'b0;
    #1 cmp(mk(24, 0, 0, 0, 0, 0));
`ifdef MEM_WB_RETIRE_COUNT_EN
    checks++;
    if (instret !== 64'd0) begin
      errors++;
      $display("FAIL instret_reset: got %0d want 0", instret);
    end
`endif
    @(negedge clk);
    #2 rst = 1'b1;

    // Capture resumes on the first edge after release: 5 valid, 1 stalled, 1 flushed.
    for (int i = 0; i < 5; i++)
      issue(0,0,1, 5'(14+i), 1, 2'b00, 3'b000, 32'(16*i+1), 0, 0, mk(25+i, 5'(14+i), 1, 32'(16*i+1), 1, 0));
    issue(1,0,1, 25, 1, 2'b00, 3'b000, 32'h5, 0, 0, mk(30, 18, 1, 32'h41, 1, 0));
    issue(0,1,1, 26, 1, 2'b00, 3'b000, 32'h6, 0, 0, mk(31, 0, 0, 0, 0, 0));
`ifdef MEM_WB_RETIRE_COUNT_EN
    checks++;
    if (instret !== 64'd5) begin
      errors++;
      $display("FAIL instret_count: got %0d want 5", instret);
    end
`endif

    stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
